// File: rtl/spi_recv_con_2_if.sv
// Pin and pixel-bus bundle for the nibble-wide SPI pixel receiver.
// The slave side is the receiver; the master side drives the link and watches pixels.
interface spi_recv_con_2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4
);
    logic [LINES-1:0]      chip_data_in;
    logic                  chip_clk_in;
    logic                  chip_sel_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid_out;
    logic [9:0]            hcount_out;
    logic [8:0]            vcount_out;
    logic                  frame_done_out;
    logic                  frag_err_out;

    modport master (
        output chip_data_in, chip_clk_in, chip_sel_in,
        input  data_out, data_valid_out, hcount_out,
        input  vcount_out, frame_done_out, frag_err_out
    );

    modport slave (
        input  chip_data_in, chip_clk_in, chip_sel_in,
        output data_out, data_valid_out, hcount_out,
        output vcount_out, frame_done_out, frag_err_out
    );
endinterface

// File: rtl/spi_recv_con_2.sv
// Nibble-wide SPI pixel receiver: sync, MSB-first byte assembly, raster addressing.
// Optional stall watchdog enabled by defining SPI_RX_TIMEOUT_EN.
module spi_recv_con_2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int LINES          = 4,
    parameter int H_PIXELS       = 320,
    parameter int V_PIXELS       = 180,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    spi_recv_con_2_if.slave  bus
);
    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef SPI_RX_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall;
`else
    typedef enum logic {IDLE, ACTIVE} state_t;
`endif

    state_t                state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [LINES-1:0]      data_sync [SYNC_STAGES];
    logic                  cs_q;
    logic                  dclk_q;
    logic [BW-1:0]         beat;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [9:0]            h_nxt;
    logic [8:0]            v_nxt;
    logic                  cs_s;
    logic                  dclk_s;
    logic [LINES-1:0]      data_s;
    logic                  rise;
    logic                  cs_fall;
    logic                  cs_rise;
    logic                  last_beat;
    logic                  frag_pend;

    // CS idles high so the chain resets to 1; data shares the DCLK depth
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cs_sync  <= '1;
            clk_sync <= '0;
            cs_q     <= 1'b1;
            dclk_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++)
                data_sync[i] <= '0;
        end else begin
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], bus.chip_sel_in};
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], bus.chip_clk_in};
            cs_q         <= cs_s;
            dclk_q       <= dclk_s;
            data_sync[0] <= bus.chip_data_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                data_sync[i] <= data_sync[i-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign dclk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign rise      = dclk_s & ~dclk_q & ~cs_s;
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign last_beat = (beat == BW'(BEATS - 1));
    assign shreg_nxt = {shreg[DATA_WIDTH-LINES-1:0], data_s};
    // beat count after this cycle's rise, seen by a coincident CS rise
    assign frag_pend = rise ? ~last_beat : (beat != '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            beat               <= '0;
            shreg              <= '0;
            h_nxt              <= '0;
            v_nxt              <= '0;
            bus.data_out       <= '0;
            bus.data_valid_out <= 1'b0;
            bus.hcount_out     <= '0;
            bus.vcount_out     <= '0;
            bus.frame_done_out <= 1'b0;
            bus.frag_err_out   <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
            stall              <= '0;
`endif
        end else begin
            bus.data_valid_out <= 1'b0;
            bus.frame_done_out <= 1'b0;
            bus.frag_err_out   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state <= ACTIVE;
                        beat  <= '0;
`ifdef SPI_RX_TIMEOUT_EN
                        stall <= '0;
`endif
                    end
                end
                ACTIVE: begin
                    if (rise) begin
                        shreg <= shreg_nxt;
`ifdef SPI_RX_TIMEOUT_EN
                        stall <= '0;
`endif
                        if (last_beat) begin
                            beat               <= '0;
                            bus.data_out       <= shreg_nxt;
                            bus.data_valid_out <= 1'b1;
                            bus.hcount_out     <= h_nxt;
                            bus.vcount_out     <= v_nxt;
                            if (h_nxt == 10'(H_PIXELS - 1)) begin
                                h_nxt <= '0;
                                if (v_nxt == 9'(V_PIXELS - 1)) begin
                                    v_nxt              <= '0;
                                    bus.frame_done_out <= 1'b1;
                                end else begin
                                    v_nxt <= v_nxt + 9'd1;
                                end
                            end else begin
                                h_nxt <= h_nxt + 10'd1;
                            end
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                    if (cs_rise) begin
                        state            <= IDLE;
                        beat             <= '0;
                        bus.frag_err_out <= frag_pend;
                    end
`ifdef SPI_RX_TIMEOUT_EN
                    else if (!rise) begin
                        if (stall == SW'(TIMEOUT_CYCLES - 1)) begin
                            state            <= HOLD;
                            beat             <= '0;
                            bus.frag_err_out <= 1'b1;
                        end else begin
                            stall <= stall + SW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (cs_rise)
                        state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_recv_con_2.sv
// Directed bench for spi_recv_con_2: single byte, row wrap, frame wrap,
// fragments, mid-transaction reset and (if enabled) the stall watchdog.
module tb_spi_recv_con_2;
    localparam int HALF = 5;
    localparam int VPIX = 3;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    int        n_valid;
    int        n_frag;
    int        n_fd;
    int        n_fd_bad;
    logic [7:0] last_data;
    logic [9:0] last_h;
    logic [8:0] last_v;
    logic [9:0] fd_h;
    logic [8:0] fd_v;

    spi_recv_con_2_if #(.DATA_WIDTH(8), .LINES(4)) bus ();

    spi_recv_con_2 #(.V_PIXELS(VPIX)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_valid = 0; n_frag = 0; n_fd = 0; n_fd_bad = 0;
        last_data = '0; last_h = '0; last_v = '0; fd_h = '0; fd_v = '0;
    end

    always @(negedge clk) begin
        if (bus.data_valid_out) begin
            n_valid   <= n_valid + 1;
            last_data <= bus.data_out;
            last_h    <= bus.hcount_out;
            last_v    <= bus.vcount_out;
        end
        if (bus.frag_err_out)
            n_frag <= n_frag + 1;
        if (bus.frame_done_out) begin
            n_fd <= n_fd + 1;
            fd_h <= bus.hcount_out;
            fd_v <= bus.vcount_out;
            if (!bus.data_valid_out)
                n_fd_bad <= n_fd_bad + 1;
        end
    end

    task automatic send_beat(input logic [3:0] nib);
        bus.chip_data_in = nib;
        bus.chip_clk_in  = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.chip_clk_in  = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_beat(b[7:4]);
        send_beat(b[3:0]);
    endtask

    task automatic cs_low();
        bus.chip_clk_in = 1'b0;
        bus.chip_sel_in = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        bus.chip_clk_in = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.chip_sel_in = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.chip_sel_in = 1'b1;
        bus.chip_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.chip_sel_in  = 1'b1;
        bus.chip_clk_in  = 1'b0;
        bus.chip_data_in = 4'h0;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.data_out !== 8'h00)
            $display("FAIL rst_data got %h want 00", bus.data_out);
        else n_pass++;
        n_total++;
        if ({bus.data_valid_out, bus.frame_done_out, bus.frag_err_out} !== 3'b000)
            $display("FAIL rst_pulses got %b want 000",
                     {bus.data_valid_out, bus.frame_done_out, bus.frag_err_out});
        else n_pass++;
        n_total++;
        if ({bus.hcount_out, bus.vcount_out} !== 19'd0)
            $display("FAIL rst_addr got %0d,%0d want 0,0", bus.hcount_out, bus.vcount_out);
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        int v0, f0;
        v0 = n_valid; f0 = n_frag;
        cs_low();
        send_byte(8'hA5);
        cs_high();
        n_total++;
        if (n_valid - v0 !== 1)
            $display("FAIL single_count got %0d want 1", n_valid - v0);
        else n_pass++;
        n_total++;
        if (last_data !== 8'hA5)
            $display("FAIL single_data got %h want a5", last_data);
        else n_pass++;
        n_total++;
        if (last_h !== 10'd0 || last_v !== 9'd0)
            $display("FAIL single_addr got %0d,%0d want 0,0", last_h, last_v);
        else n_pass++;
        n_total++;
        if (n_frag - f0 !== 0)
            $display("FAIL single_frag got %0d want 0", n_frag - f0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int v0;
        pulse_reset();
        v0 = n_valid;
        cs_low();
        for (int i = 0; i < 320; i++)
            send_byte(8'(i));
        n_total++;
        if (n_valid - v0 !== 320)
            $display("FAIL row_count got %0d want 320", n_valid - v0);
        else n_pass++;
        n_total++;
        if (last_h !== 10'd319 || last_v !== 9'd0 || last_data !== 8'h3F)
            $display("FAIL row_end got %0d,%0d,%h want 319,0,3f", last_h, last_v, last_data);
        else n_pass++;
        send_byte(8'h40);
        cs_high();
        n_total++;
        if (last_h !== 10'd0 || last_v !== 9'd1 || last_data !== 8'h40)
            $display("FAIL row_wrap got %0d,%0d,%h want 0,1,40", last_h, last_v, last_data);
        else n_pass++;
    endtask

    task automatic test_frame();
        int d0, b0;
        pulse_reset();
        d0 = n_fd; b0 = n_fd_bad;
        cs_low();
        for (int i = 0; i < 320 * VPIX - 1; i++)
            send_byte(8'(i));
        n_total++;
        if (n_fd - d0 !== 0)
            $display("FAIL frame_early got %0d want 0", n_fd - d0);
        else n_pass++;
        send_byte(8'hEE);
        n_total++;
        if (n_fd - d0 !== 1 || fd_h !== 10'd319 || fd_v !== 9'(VPIX - 1))
            $display("FAIL frame_done got n=%0d at %0d,%0d want 1 at 319,%0d",
                     n_fd - d0, fd_h, fd_v, VPIX - 1);
        else n_pass++;
        send_byte(8'h5A);
        cs_high();
        n_total++;
        if (last_h !== 10'd0 || last_v !== 9'd0 || last_data !== 8'h5A)
            $display("FAIL frame_wrap got %0d,%0d,%h want 0,0,5a", last_h, last_v, last_data);
        else n_pass++;
        n_total++;
        if (n_fd - d0 !== 1 || n_fd_bad - b0 !== 0)
            $display("FAIL frame_once got n=%0d bad=%0d want 1,0", n_fd - d0, n_fd_bad - b0);
        else n_pass++;
    endtask

    task automatic test_fragment();
        int v0, f0;
        pulse_reset();
        cs_low();
        send_byte(8'h11);
        cs_high();
        v0 = n_valid; f0 = n_frag;
        cs_low();
        send_beat(4'h3);
        cs_high();
        n_total++;
        if (n_frag - f0 !== 1 || n_valid - v0 !== 0)
            $display("FAIL frag_pulse got frag=%0d valid=%0d want 1,0",
                     n_frag - f0, n_valid - v0);
        else n_pass++;
        cs_low();
        send_byte(8'h7E);
        cs_high();
        n_total++;
        if (last_data !== 8'h7E || last_h !== 10'd1 || last_v !== 9'd0)
            $display("FAIL frag_next got %h at %0d,%0d want 7e at 1,0",
                     last_data, last_h, last_v);
        else n_pass++;
        n_total++;
        if (n_frag - f0 !== 1)
            $display("FAIL frag_clean got %0d want 1", n_frag - f0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        v0 = n_valid; f0 = n_frag;
        cs_low();
        send_beat(4'hC);
        rst_n = 1'b0;
        bus.chip_sel_in = 1'b1;
        bus.chip_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.hcount_out, bus.vcount_out} !== 19'd0 || bus.data_out !== 8'h00)
            $display("FAIL midrst_clear got %0d,%0d,%h want 0,0,00",
                     bus.hcount_out, bus.vcount_out, bus.data_out);
        else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_low();
        send_byte(8'h12);
        cs_high();
        n_total++;
        if (last_data !== 8'h12 || last_h !== 10'd0 || last_v !== 9'd0)
            $display("FAIL midrst_byte got %h at %0d,%0d want 12 at 0,0",
                     last_data, last_h, last_v);
        else n_pass++;
        n_total++;
        if (n_frag - f0 !== 0 || n_valid - v0 !== 1)
            $display("FAIL midrst_counts got frag=%0d valid=%0d want 0,1",
                     n_frag - f0, n_valid - v0);
        else n_pass++;
    endtask

`ifdef SPI_RX_TIMEOUT_EN
    task automatic test_timeout();
        int v0, f0;
        v0 = n_valid; f0 = n_frag;
        cs_low();
        send_beat(4'h9);
        repeat (1100) @(negedge clk);
        n_total++;
        if (n_frag - f0 !== 1)
            $display("FAIL tmo_frag got %0d want 1", n_frag - f0);
        else n_pass++;
        send_byte(8'h66);
        cs_high();
        n_total++;
        if (n_valid - v0 !== 0 || n_frag - f0 !== 1)
            $display("FAIL tmo_hold got valid=%0d frag=%0d want 0,1",
                     n_valid - v0, n_frag - f0);
        else n_pass++;
        cs_low();
        send_byte(8'h24);
        cs_high();
        n_total++;
        if (n_valid - v0 !== 1 || last_data !== 8'h24)
            $display("FAIL tmo_recover got valid=%0d data=%h want 1,24",
                     n_valid - v0, last_data);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.chip_sel_in  = 1'b1;
        bus.chip_clk_in  = 1'b0;
        bus.chip_data_in = 4'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame();
        test_fragment();
        test_reset_mid();
`ifdef SPI_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
